mem_reg_buf: RTL and testbench

MEM_REG_BUF -- requirements
Module: mem_reg_buf

---
 rtl/mem_reg_buf.sv | 136 +++++++++++++
 tb/tb_mem_reg_buf.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_reg_buf.sv
// rtl/mem_reg_buf.sv - circular word buffer between two request/acknowledge links
// Define MEM_REG_BUF_LEVEL_EN to expose the registered occupancy on port level.
module mem_reg_buf #(
   parameter int          REG_WIDTH = 2,
   parameter int          DEPTH     = 4,
   parameter logic [15:0] ENC       = "TP"
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_WIDTH-1:0] in_data,
   input  logic                 in_req,
   output logic                 in_ack,
   output logic [REG_WIDTH-1:0] out_data,
   output logic                 out_req,
   input  logic                 out_ack
`ifdef MEM_REG_BUF_LEVEL_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] level
`endif
);
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH+1);
   localparam bit IS_TP = (ENC == "TP");

   if (ENC != "TP" && ENC != "FP") begin : g_bad_enc
      $error("mem_reg_buf: ENC must be TP or FP");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("mem_reg_buf: DEPTH must be a power of 2 and at least 2");
   end

   typedef enum logic       {IN_IDLE, IN_ACKED}      in_state_t;
   typedef enum logic [1:0] {O_IDLE, O_REQ, O_RTZ}   out_state_t;

   logic [REG_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]        wptr, rptr;
   logic [CW-1:0]        count;
   in_state_t            in_state, in_state_n;
   out_state_t           out_state, out_state_n;
   logic                 in_ack_n, out_req_n, push, pop;
   logic [REG_WIDTH-1:0] out_data_n;

   // Input link: a word is taken only while the buffer has room (pre-edge count).
   always_comb begin
      in_state_n = in_state;
      in_ack_n   = in_ack;
      push       = 1'b0;
      if (IS_TP) begin
         if (in_req != in_ack && count < CW'(DEPTH)) begin
            push     = 1'b1;
            in_ack_n = ~in_ack;
         end
      end else begin
         case (in_state)
            IN_IDLE: begin
               if (in_req && count < CW'(DEPTH)) begin
                  push       = 1'b1;
                  in_ack_n   = 1'b1;
                  in_state_n = IN_ACKED;
               end
            end
            IN_ACKED: begin
               if (!in_req) begin
                  in_ack_n   = 1'b0;
                  in_state_n = IN_IDLE;
               end
            end
            default: in_state_n = IN_IDLE;
         endcase
      end
   end

   // Output link: the head word is latched into out_data when offered and held until popped.
   always_comb begin
      out_state_n = out_state;
      out_req_n   = out_req;
      out_data_n  = out_data;
      pop         = 1'b0;
      case (out_state)
         O_IDLE: begin
            if (count != '0) begin
               out_data_n  = mem[rptr];
               out_req_n   = IS_TP ? ~out_req : 1'b1;
               out_state_n = O_REQ;
            end
         end
         O_REQ: begin
            if (IS_TP) begin
               if (out_ack == out_req) begin
                  pop         = 1'b1;
                  out_state_n = O_IDLE;
               end
            end else if (out_ack) begin
               pop         = 1'b1;
               out_req_n   = 1'b0;
               out_state_n = O_RTZ;
            end
         end
         O_RTZ: begin
            if (!out_ack) out_state_n = O_IDLE;
         end
         default: out_state_n = O_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         in_state  <= IN_IDLE;
         out_state <= O_IDLE;
         in_ack    <= 1'b0;
         out_req   <= 1'b0;
         out_data  <= '0;
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
      end else begin
         in_state  <= in_state_n;
         out_state <= out_state_n;
         in_ack    <= in_ack_n;
         out_req   <= out_req_n;
         out_data  <= out_data_n;
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= in_data;
   end

`ifdef MEM_REG_BUF_LEVEL_EN
   assign level = count;
`endif

endmodule

// File: tb/tb_mem_reg_buf.sv
// tb/tb_mem_reg_buf.sv - scoreboard bench driving one two-phase and one four-phase buffer
`timescale 1ns/1ps
module tb_mem_reg_buf;
   localparam int W = 2;
   localparam int D = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [W-1:0] tp_in_data = '0, fp_in_data = '0, tp_out_data, fp_out_data;
   logic tp_in_req = 1'b0, fp_in_req = 1'b0, tp_out_ack = 1'b0, fp_out_ack = 1'b0;
   logic tp_in_ack, fp_in_ack, tp_out_req, fp_out_req;
`ifdef MEM_REG_BUF_LEVEL_EN
   logic [2:0] tp_level, fp_level;
`endif

   mem_reg_buf #(.REG_WIDTH(W), .DEPTH(D), .ENC("TP")) u_tp (
      .clk(clk), .rst(rst), .in_data(tp_in_data), .in_req(tp_in_req), .in_ack(tp_in_ack),
      .out_data(tp_out_data), .out_req(tp_out_req), .out_ack(tp_out_ack)
`ifdef MEM_REG_BUF_LEVEL_EN
      , .level(tp_level)
`endif
   );

   mem_reg_buf #(.REG_WIDTH(W), .DEPTH(D), .ENC("FP")) u_fp (
      .clk(clk), .rst(rst), .in_data(fp_in_data), .in_req(fp_in_req), .in_ack(fp_in_ack),
      .out_data(fp_out_data), .out_req(fp_out_req), .out_ack(fp_out_ack)
`ifdef MEM_REG_BUF_LEVEL_EN
      , .level(fp_level)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] tp_q[$];
   logic [W-1:0] fp_q[$];
   int tp_acc = 0, tp_pop = 0, fp_acc = 0, fp_pop = 0;
   int tp_acc_cyc = 0, tp_pres_cyc = 0, fp_acc_cyc = 0, fp_pres_cyc = 0;
   int tp_first_ack = 0;
   int tp_rx_mode = 0, fp_rx_mode = 0;   // 0 answer at once, 1 answer at random, 2 withhold
   bit fp_fast = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Two-phase receiver and scoreboard monitor
   logic         tp_prev_req = 1'b0, tp_prev_in_ack = 1'b0;
   logic [W-1:0] tp_held = '0;
   bit           tp_pop_pend = 1'b0;
   initial begin : mon_tp
      forever begin
         @(negedge clk);
         if (!rst) begin
            tp_prev_req = 1'b0; tp_prev_in_ack = 1'b0; tp_pop_pend = 1'b0;
            tp_acc = 0; tp_pop = 0; tp_out_ack = 1'b0;
            continue;
         end
         if (tp_in_ack != tp_prev_in_ack) tp_acc++;
         tp_prev_in_ack = tp_in_ack;
         if (tp_pop_pend) begin tp_pop++; tp_pop_pend = 1'b0; end
`ifdef MEM_REG_BUF_LEVEL_EN
         check("tp_level", int'(tp_level), tp_acc - tp_pop);
`endif
         if (tp_out_req != tp_prev_req) begin
            check("tp_word_expected", int'(tp_q.size() > 0), 1);
            if (tp_q.size() > 0) check("tp_data", int'(tp_out_data), int'(tp_q.pop_front()));
            tp_pres_cyc = cyc;
            tp_held = tp_out_data;
         end else if (tp_out_req != tp_out_ack) begin
            check("tp_data_stable", int'(tp_out_data), int'(tp_held));
         end
         tp_prev_req = tp_out_req;
         if (tp_out_req != tp_out_ack && tp_rx_mode != 2 &&
             (tp_rx_mode == 0 || $urandom_range(0, 2) == 0)) begin
            tp_out_ack = tp_out_req;
            tp_pop_pend = 1'b1;
            if (tp_first_ack < 0) tp_first_ack = cyc;
         end
      end
   end

   // Four-phase receiver and scoreboard monitor
   logic         fp_prev_req = 1'b0, fp_prev_in_ack = 1'b0;
   logic [W-1:0] fp_held = '0;
   bit           fp_pop_pend = 1'b0;
   initial begin : mon_fp
      forever begin
         @(negedge clk);
         if (!rst) begin
            fp_prev_req = 1'b0; fp_prev_in_ack = 1'b0; fp_pop_pend = 1'b0;
            fp_acc = 0; fp_pop = 0; fp_out_ack = 1'b0;
            continue;
         end
         if (fp_in_ack && !fp_prev_in_ack) fp_acc++;
         fp_prev_in_ack = fp_in_ack;
         if (fp_pop_pend) begin fp_pop++; fp_pop_pend = 1'b0; end
`ifdef MEM_REG_BUF_LEVEL_EN
         check("fp_level", int'(fp_level), fp_acc - fp_pop);
`endif
         if (fp_fast) check("fp_occupancy_le2", int'(fp_acc - fp_pop <= 2), 1);
         if (fp_out_req && !fp_prev_req) begin
            check("fp_word_expected", int'(fp_q.size() > 0), 1);
            if (fp_q.size() > 0) check("fp_data", int'(fp_out_data), int'(fp_q.pop_front()));
            fp_pres_cyc = cyc;
            fp_held = fp_out_data;
         end else if (fp_out_req && fp_prev_req) begin
            check("fp_data_stable", int'(fp_out_data), int'(fp_held));
         end
         fp_prev_req = fp_out_req;
         if (fp_out_req && !fp_out_ack && fp_rx_mode != 2 &&
             (fp_rx_mode == 0 || $urandom_range(0, 2) == 0)) begin
            fp_out_ack = 1'b1;
            fp_pop_pend = 1'b1;
         end else if (!fp_out_req && fp_out_ack) begin
            fp_out_ack = 1'b0;
         end
      end
   end

   task automatic tp_send(input logic [W-1:0] d, input int budget, output bit ok);
      tp_in_data = d;
      tp_q.push_back(d);
      tp_in_req = ~tp_in_req;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (tp_in_ack == tp_in_req) begin ok = 1'b1; tp_acc_cyc = cyc; break; end
      end
   endtask

   task automatic fp_send(input logic [W-1:0] d, input int budget, input int gap, output bit ok);
      bit up = 1'b0, down = 1'b0;
      fp_in_data = d;
      fp_q.push_back(d);
      fp_in_req = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (fp_in_ack) begin up = 1'b1; fp_acc_cyc = cyc; break; end
      end
      fp_in_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (!fp_in_ack) begin down = 1'b1; break; end
      end
      repeat (gap) @(negedge clk);
      ok = up && down;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tp_in_req = 1'b0;
      fp_in_req = 1'b0;
      tp_q.delete();
      fp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_tp_in_ack"},   int'(tp_in_ack),   0);
      check({tag, "_tp_out_req"},  int'(tp_out_req),  0);
      check({tag, "_tp_out_data"}, int'(tp_out_data), 0);
      check({tag, "_fp_in_ack"},   int'(fp_in_ack),   0);
      check({tag, "_fp_out_req"},  int'(fp_out_req),  0);
      check({tag, "_fp_out_data"}, int'(fp_out_data), 0);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         done = (tp_q.size() == 0) && (fp_q.size() == 0) && (tp_out_req == tp_out_ack) &&
                !fp_out_req && !fp_out_ack;
      end
      check({tag, "_drained"}, int'(done), 1);
   endtask

   initial begin : main
      bit ok;
      repeat (2) @(negedge clk);
      do_reset();
      check_reset_state("reset");

      // Single words into an empty buffer: offered one edge after acceptance
      for (int d = 1; d <= 3; d++) begin
         tp_send(W'(d), 4, ok);
         check("tp_accept", int'(ok), 1);
         repeat (3) @(negedge clk);
         check("tp_latency", tp_pres_cyc - tp_acc_cyc, 1);
         fp_send(W'(d), 4, 0, ok);
         check("fp_handshake", int'(ok), 1);
         repeat (3) @(negedge clk);
         check("fp_latency", fp_pres_cyc - fp_acc_cyc, 1);
      end
      wait_drain("single", 20);

      // Full buffer: fifth word stalls until the first pop
      tp_rx_mode = 2;
      for (int d = 0; d < 4; d++) begin
         tp_send(W'(d), 2, ok);
         check("tp_fill_accept", int'(ok), 1);
      end
      tp_in_data = 2'd2;
      tp_q.push_back(2'd2);
      tp_in_req = ~tp_in_req;
      repeat (5) @(negedge clk);
      check("tp_full_stall", int'(tp_in_ack != tp_in_req), 1);
`ifdef MEM_REG_BUF_LEVEL_EN
      check("tp_full_level", int'(tp_level), 4);
`endif
      tp_first_ack = -1;
      tp_rx_mode = 0;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (tp_in_ack == tp_in_req) begin ok = 1'b1; tp_acc_cyc = cyc; break; end
      end
      check("tp_full_release", int'(ok), 1);
      check("tp_release_timing", tp_acc_cyc - tp_first_ack, 2);
      wait_drain("full", 40);

      // Four-phase sender and receiver both answering every cycle
      fp_fast = 1'b1;
      for (int i = 0; i < 12; i++) begin
         fp_send(W'($urandom_range(0, 3)), 6, 1, ok);
         check("fp_fast_handshake", int'(ok), 1);
      end
      wait_drain("fp_fast", 20);
      fp_fast = 1'b0;

      // Back-to-back two-phase stream across several pointer wraps
      for (int i = 0; i < 16; i++) begin
         tp_send(W'($urandom_range(0, 3)), 10, ok);
         check("tp_stream_accept", int'(ok), 1);
      end
      wait_drain("tp_stream", 60);

      // Randomised traffic on both links with random receiver stalls
      tp_rx_mode = 1;
      fp_rx_mode = 1;
      fork
         begin
            bit k;
            for (int i = 0; i < 40; i++) begin
               tp_send(W'($urandom_range(0, 3)), 60, k);
               check("tp_rand_accept", int'(k), 1);
               repeat ($urandom_range(0, 2)) @(negedge clk);
            end
         end
         begin
            bit k;
            for (int i = 0; i < 40; i++) begin
               fp_send(W'($urandom_range(0, 3)), 60, $urandom_range(0, 2), k);
               check("fp_rand_handshake", int'(k), 1);
            end
         end
      join
      tp_rx_mode = 0;
      fp_rx_mode = 0;
      wait_drain("random", 200);

      // Reset with words stored and a request outstanding
      tp_rx_mode = 2;
      fp_rx_mode = 2;
      tp_send(2'd3, 2, ok);
      tp_send(2'd1, 2, ok);
      tp_send(2'd2, 2, ok);
      fp_send(2'd3, 4, 0, ok);
      fp_send(2'd1, 4, 0, ok);
      fp_send(2'd2, 4, 0, ok);
      @(negedge clk);
      check("pre_reset_tp_out_req", int'(tp_out_req), 1);
      check("pre_reset_fp_out_req", int'(fp_out_req), 1);
`ifdef MEM_REG_BUF_LEVEL_EN
      check("pre_reset_tp_level", int'(tp_level), 3);
`endif
      do_reset();
      check_reset_state("midreset");
`ifdef MEM_REG_BUF_LEVEL_EN
      check("midreset_tp_level", int'(tp_level), 0);
`endif
      tp_rx_mode = 0;
      fp_rx_mode = 0;
      tp_send(2'd2, 4, ok);
      check("post_reset_tp_accept", int'(ok), 1);
      fp_send(2'd2, 4, 0, ok);
      check("post_reset_fp_handshake", int'(ok), 1);
      wait_drain("post_reset", 30);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
